// File: rtl/prg_loader.sv
// prg_loader: turns PRG/CRT download bytes into buffered SDRAM writes, then
// patches the BASIC end-of-program pointers and optionally requests a core reset.
module prg_loader #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] CART_BASE  = 16'hA000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic [7:0]  dl_index,
  input  logic        dl_wr,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        use_header,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  input  logic        mem_ack,
  output logic        busy,
  output logic [15:0] end_addr,
  output logic        auto_reset,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_INJECT, S_PULSE} state_t;
  state_t        r_state;
  logic          r_dl_d, r_hdr, r_armed, r_overflow, r_auto_reset;
  logic [15:0]   r_cur_addr, r_end_addr;
  logic [2:0]    r_inj_idx;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic [15:0]   r_fa [FIFO_DEPTH];
  logic [7:0]    r_fd [FIFO_DEPTH];
  logic          w_rise, w_fall, w_ne, w_full, w_pop, w_load_wr, w_is_data, w_push, w_drop;
  logic [15:0]   w_push_addr, w_inj_addr;
  assign w_rise      = dl_active & ~r_dl_d;
  assign w_fall      = ~dl_active & r_dl_d;
  assign w_ne        = r_cnt != '0;
  assign w_full      = r_cnt == FULL_CNT;
  assign w_pop       = w_ne && mem_ack;
  assign w_load_wr   = r_state == S_LOAD && dl_wr && dl_index != 8'd0;
  assign w_is_data   = w_load_wr && (!r_hdr || dl_addr >= 16'd2);
  assign w_push_addr = (!r_hdr && dl_addr == 16'd0) ? CART_BASE : r_cur_addr;
  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign w_push      = w_is_data && (!w_full || w_pop);
  assign w_drop      = w_is_data && !w_push;
  assign w_inj_addr  = r_inj_idx < 3'd6 ? {8'h00, 8'h2D + {5'd0, r_inj_idx}}
                                        : {8'h00, 8'hA8 + {5'd0, r_inj_idx}};
  assign mem_req    = w_ne || r_state == S_INJECT;
  assign mem_addr   = r_state == S_INJECT ? w_inj_addr : w_ne ? r_fa[r_rp] : 16'h0;
  assign mem_data   = r_state == S_INJECT ? (r_inj_idx[0] ? r_end_addr[15:8] : r_end_addr[7:0])
                                          : w_ne ? r_fd[r_rp] : 8'h0;
  assign busy       = r_state != S_IDLE;
  assign end_addr   = r_end_addr;
  assign auto_reset = r_auto_reset;
  assign overflow   = r_overflow;
  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_fa[r_wp] <= w_push_addr;
      r_fd[r_wp] <= dl_data;
    end
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_dl_d       <= 1'b0;
      r_hdr        <= 1'b0;
      r_armed      <= 1'b0;
      r_overflow   <= 1'b0;
      r_auto_reset <= 1'b0;
      r_cur_addr   <= 16'h0;
      r_end_addr   <= 16'h0;
      r_inj_idx    <= 3'd0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_cnt        <= '0;
    end else begin
      r_dl_d       <= dl_active;
      r_auto_reset <= 1'b0;
      r_cnt        <= (w_push && !w_pop) ? r_cnt + 1'b1 : (!w_push && w_pop) ? r_cnt - 1'b1 : r_cnt;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_push && w_push_addr == CART_BASE) r_armed <= 1'b1;
      if (w_is_data) r_cur_addr <= w_push_addr + 16'd1;
      else if (w_load_wr && dl_addr == 16'd0) r_cur_addr[7:0] <= dl_data;
      else if (w_load_wr && dl_addr == 16'd1) r_cur_addr[15:8] <= dl_data;
      if (w_drop || (dl_wr && r_state != S_IDLE && !w_load_wr)) r_overflow <= 1'b1;
      case (r_state)
        S_IDLE: if (w_rise && dl_index != 8'd0) begin
          r_state    <= S_LOAD;
          r_hdr      <= dl_index[4:0] == 5'd1 || use_header;
          r_overflow <= 1'b0;
          r_armed    <= 1'b0;
          r_cur_addr <= 16'h0;
        end
        S_LOAD: if (w_fall) begin
          r_state    <= S_DRAIN;
          r_end_addr <= r_cur_addr;
        end
        S_DRAIN: if (!w_ne) begin
          r_state   <= S_INJECT;
          r_inj_idx <= 3'd0;
        end
        S_INJECT: if (mem_ack) begin
          r_inj_idx <= r_inj_idx + 3'd1;
          if (r_inj_idx == 3'd7) begin
            r_state      <= S_PULSE;
            r_auto_reset <= r_armed;
          end
        end
        S_PULSE: begin
          r_armed <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prg_loader.sv
// tb_prg_loader: directed and randomized downloads checked against a write-list model.
module tb_prg_loader;
  logic        clk_sys = 0, reset = 1, dl_active = 0, dl_wr = 0, use_header = 0, mem_ack = 0;
  logic [7:0]  dl_index = 0, dl_data = 0;
  logic [15:0] dl_addr = 0;
  logic        mem_req, busy, auto_reset, overflow;
  logic [15:0] mem_addr, end_addr;
  logic [7:0]  mem_data;
  int checks = 0, failures = 0, ack_mode = 1;
  int ar_cnt = 0, req_seen = 0, busy_seen = 0;
  logic [15:0] wa[$], ea[$];
  logic [7:0]  wd[$], ed[$], db[$];
  logic [15:0] exp_end;
  logic        exp_arm;
  logic [7:0]  inj_a [8] = '{8'h2D, 8'h2E, 8'h2F, 8'h30, 8'h31, 8'h32, 8'hAE, 8'hAF};

  prg_loader dut (
    .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_index(dl_index),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .use_header(use_header),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .busy(busy), .end_addr(end_addr), .auto_reset(auto_reset), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  initial forever begin
    @(posedge clk_sys); #1;
    mem_ack = ack_mode == 2 ? 1'($urandom % 2) : (ack_mode == 1);
  end

  always @(negedge clk_sys) begin
    if (mem_req && mem_ack) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
    end
    if (auto_reset) ar_cnt++;
    if (mem_req) req_seen++;
    if (busy) busy_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic strobe(input logic [15:0] a, input logic [7:0] d);
    cyc(1); dl_wr = 1; dl_addr = a; dl_data = d;
    cyc(1); dl_wr = 0;
  endtask

  task automatic begin_dl(input logic [7:0] idx, input logic uh);
    cyc(1); dl_index = idx; use_header = uh; dl_active = 1;
    cyc(1);
  endtask

  task automatic end_dl();
    cyc(1); dl_active = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin cyc(1); n++; end
    chk({tag, " idle"}, busy, 0);
    cyc(2);
  endtask

  task automatic send(input logic [7:0] idx, input logic uh, input logic [15:0] ha, input int wbase, input bit pace);
    logic he = uh || idx[4:0] == 5'd1;
    begin_dl(idx, uh);
    if (he) begin strobe(16'd0, ha[7:0]); strobe(16'd1, ha[15:8]); end
    foreach (db[i]) begin
      int n = 0;
      while (pace && i - (wa.size() - wbase) >= 4 && n < 1000) begin cyc(1); n++; end
      strobe(16'(i) + (he ? 16'd2 : 16'd0), db[i]);
    end
    end_dl();
  endtask

  // Expected writes: the first 'keep' data bytes at consecutive addresses, then the pointer patch.
  task automatic expect_run(input logic [15:0] base, input logic hdr, input int keep);
    ea.delete(); ed.delete();
    exp_arm = 0;
    for (int i = 0; i < keep; i++) begin
      ea.push_back(base + 16'(i));
      ed.push_back(db[i]);
      if (base + 16'(i) == 16'hA000) exp_arm = 1;
    end
    exp_end = (hdr || db.size() > 0) ? base + 16'(db.size()) : 16'h0;
    for (int k = 0; k < 8; k++) begin
      ea.push_back({8'h00, inj_a[k]});
      ed.push_back(k % 2 == 0 ? exp_end[7:0] : exp_end[15:8]);
    end
  endtask

  task automatic compare_run(input string tag, input int wbase, input int arbase);
    chk({tag, " end_addr"}, end_addr, exp_end);
    chk({tag, " nwrites"}, wa.size() - wbase, ea.size());
    for (int i = 0; i < ea.size(); i++)
      if (wbase + i < wa.size()) begin
        chk($sformatf("%s addr[%0d]", tag, i), wa[wbase+i], ea[i]);
        chk($sformatf("%s data[%0d]", tag, i), wd[wbase+i], ed[i]);
      end
    chk({tag, " auto_reset"}, ar_cnt - arbase, exp_arm);
  endtask

  initial begin
    int wb, ab, rb, bb, n;
    logic [7:0] idx;
    logic uh, he;
    logic [15:0] ha;
    cyc(2);
    chk("rst mem_req", mem_req, 0);
    chk("rst busy", busy, 0);
    chk("rst auto_reset", auto_reset, 0);
    chk("rst overflow", overflow, 0);
    chk("rst end_addr", end_addr, 0);
    chk("rst mem_addr", mem_addr, 0);
    reset = 0;
    cyc(1);

    wb = wa.size(); ab = ar_cnt;
    db = '{8'hAA, 8'hBB, 8'hCC};
    begin_dl(8'd2, 1);
    strobe(16'd0, 8'h01); strobe(16'd1, 8'h10);
    strobe(16'd2, 8'hAA);
    chk("prg latency req", mem_req, 1);
    chk("prg latency addr", mem_addr, 16'h1001);
    chk("prg latency data", mem_data, 8'hAA);
    chk("prg busy", busy, 1);
    strobe(16'd3, 8'hBB); strobe(16'd4, 8'hCC);
    end_dl();
    wait_idle("prg");
    expect_run(16'h1001, 1, 3);
    compare_run("prg", wb, ab);

    wb = wa.size(); ab = ar_cnt;
    db = '{8'h11, 8'h22};
    send(8'd2, 0, 16'h0, wb, 0);
    wait_idle("cart");
    expect_run(16'hA000, 0, 2);
    compare_run("cart", wb, ab);

    ack_mode = 0; cyc(2);
    wb = wa.size(); ab = ar_cnt;
    db = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
    send(8'd2, 1, 16'h2000, wb, 0);
    cyc(3);
    chk("bp overflow", overflow, 1);
    chk("bp req held", mem_req, 1);
    chk("bp head addr", mem_addr, 16'h2000);
    chk("bp head data", mem_data, 8'hD0);
    chk("bp no writes", wa.size() - wb, 0);
    ack_mode = 1;
    wait_idle("bp");
    expect_run(16'h2000, 1, 4);
    compare_run("bp", wb, ab);

    wb = wa.size(); ab = ar_cnt;
    db = '{8'h01, 8'h02};
    send(8'd2, 1, 16'hFFFF, wb, 0);
    wait_idle("wrap");
    chk("wrap overflow cleared", overflow, 0);
    expect_run(16'hFFFF, 1, 2);
    compare_run("wrap", wb, ab);

    wb = wa.size(); ab = ar_cnt;
    db = '{8'h33, 8'h44, 8'h55};
    send(8'd2, 0, 16'h0, wb, 0);
    n = 0;
    while (wa.size() - wb < 6 && n < 200) begin cyc(1); n++; end
    chk("rstinj reached", wa.size() - wb, 6);
    #2 reset = 1;
    #1;
    chk("rstinj mem_req", mem_req, 0);
    chk("rstinj busy", busy, 0);
    chk("rstinj auto_reset", auto_reset, 0);
    cyc(2);
    reset = 0;
    cyc(3);
    chk("rstinj no pulse", ar_cnt - ab, 0);
    chk("rstinj end_addr", end_addr, 0);
    wb = wa.size(); ab = ar_cnt;
    db = '{8'h5A};
    send(8'd2, 1, 16'h3000, wb, 0);
    wait_idle("post");
    expect_run(16'h3000, 1, 1);
    compare_run("post", wb, ab);

    rb = req_seen; bb = busy_seen;
    begin_dl(8'd0, 0);
    for (int i = 0; i < 16; i++) strobe(16'(i), 8'(i * 7));
    end_dl();
    cyc(3);
    chk("rom req", req_seen - rb, 0);
    chk("rom busy", busy_seen - bb, 0);
    chk("rom overflow", overflow, 0);

    ack_mode = 2;
    for (int t = 0; t < 25; t++) begin
      idx = 8'($urandom_range(1, 255));
      uh = 1'($urandom % 2);
      he = uh || idx[4:0] == 5'd1;
      n = $urandom_range(0, 9);
      case ($urandom % 4)
        0: ha = 16'hA000 - 16'($urandom_range(0, 3));
        1: ha = 16'hFFFF - 16'($urandom_range(0, 3));
        default: ha = 16'($urandom);
      endcase
      db.delete();
      for (int i = 0; i < n; i++) db.push_back(8'($urandom));
      wb = wa.size(); ab = ar_cnt;
      send(idx, uh, ha, wb, 1);
      wait_idle($sformatf("rnd%0d", t));
      expect_run(he ? ha : 16'hA000, he, n);
      compare_run($sformatf("rnd%0d", t), wb, ab);
      chk($sformatf("rnd%0d overflow", t), overflow, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prg_loader.md
Name: prg_loader

Overview:
- Sits between the data_io download stream and the SDRAM write port.
- Turns PRG/CRT file bytes into addressed memory writes through a 4-entry request FIFO with a req/ack handshake.
- After a download it writes the BASIC end-of-program pointers into zero page, then optionally pulses a core reset for carts loaded at $A000.
- Ignores ROM downloads (index 0); those are handled elsewhere.

Parameters:
- FIFO_DEPTH, 4, number of {addr,data} entries buffered toward memory; power of two, at least 2.
- CART_BASE, 16'hA000, load address used in headerless mode; a write to this address arms auto-reset.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- dl_active  in  1  download in progress (data_io downloading).
- dl_index  in  8  file index of the current download; 0 = ROM, so the block stays idle.
- dl_wr  in  1  single-cycle byte strobe.
- dl_addr  in  16  byte offset within the file.
- dl_data  in  8  file byte.
- use_header  in  1  1 = the first two bytes are the load address (lo, hi).
- mem_req  out  1  write request valid.
- mem_addr  out  16  write address.
- mem_data  out  8  write data.
- mem_ack  in  1  write accepted this cycle.
- busy  out  1  state is not IDLE.
- end_addr  out  16  address following the last byte written.
- auto_reset  out  1  one-cycle core reset request.
- overflow  out  1  sticky: a byte was dropped.

Behaviour:
- Reset (asynchronous): all outputs 0, FIFO empty, state IDLE, auto-reset not armed. mem_req drops immediately, including mid-transfer.
- States are IDLE, LOAD, DRAIN, INJECT and PULSE.
- IDLE -> LOAD: on the rising edge of dl_active with dl_index != 0. Entering LOAD clears overflow, the armed flag and cur_addr (cur_addr = 0).
- Header mode applies when dl_index[4:0] == 1 or use_header == 1, and is latched at LOAD entry.
  - Offset 0 loads cur_addr[7:0]; offset 1 loads cur_addr[15:8].
  - Offsets 2 and above push {cur_addr, dl_data}, then cur_addr increments.
- Headerless mode: offset 0 sets the pushed address to CART_BASE; each push increments cur_addr.
- Address arithmetic is 16-bit and wraps $FFFF -> $0000.
- A push whose address equals CART_BASE sets the armed flag.
- FIFO full when dl_wr arrives: the byte is dropped, overflow is set, and cur_addr still increments so later bytes land at their correct addresses.
- dl_wr outside LOAD, or while dl_index == 0: ignored. overflow is set only if busy.
- Latency: dl_wr in cycle n gives mem_req high in cycle n+1 when the FIFO was empty.
- Handshake:
  - mem_req = FIFO not empty (LOAD/DRAIN) or an injection is pending (INJECT).
  - mem_addr and mem_data come from the FIFO head and stay stable until a cycle with mem_req && mem_ack, which pops the head.
  - Simultaneous push and pop is allowed when the FIFO is full: the pop frees the slot and the push is accepted.
- LOAD -> DRAIN: on the falling edge of dl_active. end_addr <= cur_addr in the same cycle.
- DRAIN -> INJECT: when the FIFO is empty.
- INJECT issues 8 writes in order, each held until acked:
  - $2D = end_addr lo, $2E = end_addr hi
  - $2F = end_addr lo, $30 = end_addr hi
  - $31 = end_addr lo, $32 = end_addr hi
  - $AE = end_addr lo, $AF = end_addr hi
- INJECT -> PULSE: after the 8th ack. In PULSE, auto_reset = armed for exactly one cycle and armed clears. Next state is IDLE.
- A download with no data bytes still injects, using end_addr = cur_addr: the header address, or 0 in headerless mode.
- dl_active rising while in DRAIN, INJECT or PULSE: the new download is ignored until IDLE, and its strobes set overflow.
- mem_ack while mem_req = 0: ignored.

Test Plan:
- Header PRG: index 2, use_header = 1, bytes 01 10 AA BB CC, mem_ack always 1.
  - Writes $1001=AA, $1002=BB, $1003=CC.
  - end_addr = $1004.
  - Injects $2D=04 $2E=10 $2F=04 $30=10 $31=04 $32=10 $AE=04 $AF=10.
  - auto_reset stays 0 and busy returns to 0.
- Headerless cart: index 2, use_header = 0, bytes 11 22.
  - Writes $A000=11, $A001=22; end_addr = $A002.
  - Injected pointer bytes are 02/A0.
  - auto_reset is high for exactly one cycle after the $AF ack.
- Backpressure: mem_ack held 0, six strobes with data D0..D5 at offsets 2..7 after header 00 20.
  - FIFO holds $2000..$2003; D4 and D5 are dropped and overflow = 1.
  - On releasing ack, writes arrive in order. end_addr = $2006.
- Wrap: header FF FF, bytes 01 02 -> $FFFF=01, $0000=02, end_addr = $0001.
- Reset asserted mid-INJECT (after 3 acks): mem_req, busy and auto_reset go to 0 asynchronously. A following header download 00 30 5A behaves as in the first scenario: $3000=5A, end_addr = $3001.
- Index 0 download with 16 strobes -> mem_req never asserts, busy stays 0, overflow stays 0.
